rw_flow: RTL and testbench
==========================

// Module: rw_flow
// PURPOSE
//  Command-flow controller between the command decoder, the memory and the serial transmitter.
//  Accepts a validated read/write command while the block is Active in Mode 1.
//  Sequences the memory access; for reads it then samples the memory data and hands it to the
//  transmitter, waiting for TxDone. Busy tells upstream logic that no new command is accepted.
// PARAMETERS
//  ACCESS_CYCLES  1  cycles AccessMem is held per access, legal range 1..15
// PORTS
//  Clk         in   1  system clock; all state changes on the rising edge
//  Reset       in   1  asynchronous, active-low reset
//  Active      in   1  block enable; 0 aborts any flow
//  Mode        in   1  1 = command/memory mode served by this block; 0 = commands ignored
//  ValidCmd    in   1  single-cycle strobe: decoded command is valid
//  RW          in   1  command direction: 0 = read, 1 = write; sampled with ValidCmd
//  TxDone      in   1  transmitter finished sending the sampled data
//  AccessMem   out  1  memory access strobe
//  RWMem       out  1  memory direction (copy of latched RW), valid while AccessMem=1
//  SampleData  out  1  one-cycle strobe: capture memory read data into the TX register
//  TxData      out  1  request transmitter to send; held until TxDone
//  Busy        out  1  flow in progress; high in every state except IDLE
// BEHAVIOUR
//  - All outputs are registered; Moore outputs are decoded from the state register only.
//  - Reset (Reset=0, async): state=IDLE; AccessMem=RWMem=SampleData=TxData=Busy=0;
//    latched RW=0; counter=0.
//  - States: IDLE, ACCESS, SAMPLE, TX, DONE.
//  - IDLE: outputs 0. On an edge with Active=1, Mode=1 and ValidCmd=1:
//    latch RW, load counter=ACCESS_CYCLES-1, go to ACCESS. Otherwise stay in IDLE.
//  - ACCESS: AccessMem=1, RWMem=latched RW, Busy=1. Counter decrements each cycle.
//    At count 0: read goes to SAMPLE; write goes to DONE.
//    AccessMem is therefore high for exactly ACCESS_CYCLES cycles.
//  - SAMPLE: SampleData=1, Busy=1 for exactly one cycle, then go to TX.
//  - TX: TxData=1, Busy=1. Stay until TxDone=1 is sampled on an edge, then go to IDLE.
//    TxDone arriving in any other state is ignored.
//  - DONE: Busy=1, all strobes 0, for one cycle, then go to IDLE (write completion/turnaround).
//  - Latency at ACCESS_CYCLES=1, cycles counted from the edge that accepts ValidCmd:
//    - read: AccessMem in cycle 1, SampleData in cycle 2, TxData from cycle 3 until the
//      edge sampling TxDone=1; Busy drops on that same edge.
//    - write: AccessMem in cycle 1, DONE in cycle 2, Busy low from cycle 3.
//  - ValidCmd while Busy=1 is ignored; it is neither queued nor able to change latched RW.
//  - Abort: Active=0 sampled in any state forces IDLE on that edge and clears all outputs.
//  - Mode=0 mid-flow does NOT abort; the current flow completes. Mode=0 only blocks new
//    commands in IDLE.
//  - ValidCmd and TxDone high on the same edge in TX: the TX->IDLE transition wins and the
//    new command is dropped.
//  - Any illegal/unused state encoding recovers to IDLE on the next edge.
//  - Reset asserted mid-flow clears everything immediately, without waiting for a clock edge.
// TESTING
//  1 Reset=0 for 2 cycles, then 1 with inputs 0: all outputs 0, Busy=0.
//  2 Read (Active=Mode=1, RW=0, ValidCmd 1 cycle): AccessMem=1,RWMem=0 1 cyc; SampleData 1 cyc;
//    TxData held 16 cyc until TxDone=1 pulse; Busy=0 next cycle.
//  3 Write (RW=1): AccessMem=1,RWMem=1 1 cyc; Busy high 2 cyc total; SampleData/TxData never 1.
//  4 ValidCmd with Mode=0 or Active=0: no output ever asserts.
//  5 Extra ValidCmd (RW=1) during TX of a read: ignored, RWMem stays 0; Active=0 in TX -> IDLE next edge.
//  6 ACCESS_CYCLES=3 read: AccessMem high exactly 3 cycles. Reset=0 mid-TX: outputs 0 immediately.

Source files
------------

// File: rtl/rw_flow_if.sv
// Command/memory/transmitter handshake bundle for the read/write flow controller.
interface rw_flow_if;
  logic active;
  logic mode;
  logic valid_cmd;
  logic rw;
  logic tx_done;
  logic access_mem;
  logic rw_mem;
  logic sample_data;
  logic tx_data;
  logic busy;

  // Upstream side: decoder, enable logic and transmitter status.
  modport master (
    output active, mode, valid_cmd, rw, tx_done,
    input  access_mem, rw_mem, sample_data, tx_data, busy
  );

  // Controller side.
  modport slave (
    input  active, mode, valid_cmd, rw, tx_done,
    output access_mem, rw_mem, sample_data, tx_data, busy
  );
endinterface

// File: rtl/rw_flow.sv
// Command-flow controller: sequences a memory access per accepted command and,
// for reads, samples the memory data and hands it to the serial transmitter.
//
//  state  | meaning
//  IDLE   | waiting for a command (active, mode and valid_cmd all high)
//  ACCESS | memory strobe held for ACCESS_CYCLES cycles
//  SAMPLE | one-cycle capture of read data into the TX register
//  TX     | transmit request held until tx_done
//  DONE   | one-cycle write turnaround before returning to IDLE
module rw_flow #(
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  rw_flow_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    SAMPLE = 3'd2,
    TX     = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       rw_lat;

  // Outputs are registered alongside the state: each transition also loads the
  // output pattern of the state being entered, so outputs always match state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      rw_lat          <= 1'b0;
      bus.access_mem  <= 1'b0;
      bus.rw_mem      <= 1'b0;
      bus.sample_data <= 1'b0;
      bus.tx_data     <= 1'b0;
      bus.busy        <= 1'b0;
    end else if (!bus.active) begin
      state           <= IDLE;
      bus.access_mem  <= 1'b0;
      bus.rw_mem      <= 1'b0;
      bus.sample_data <= 1'b0;
      bus.tx_data     <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mode && bus.valid_cmd) begin
            state          <= ACCESS;
            rw_lat         <= bus.rw;
            cnt            <= CNT_LOAD;
            bus.access_mem <= 1'b1;
            bus.rw_mem     <= bus.rw;
            bus.busy       <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            bus.access_mem <= 1'b0;
            bus.rw_mem     <= 1'b0;
            if (rw_lat) begin
              state <= DONE;
            end else begin
              state           <= SAMPLE;
              bus.sample_data <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        SAMPLE: begin
          state           <= TX;
          bus.sample_data <= 1'b0;
          bus.tx_data     <= 1'b1;
        end
        TX: begin
          // A command arriving with tx_done is dropped: the block is still busy here.
          if (bus.tx_done) begin
            state       <= IDLE;
            bus.tx_data <= 1'b0;
            bus.busy    <= 1'b0;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state           <= IDLE;
          bus.access_mem  <= 1'b0;
          bus.rw_mem      <= 1'b0;
          bus.sample_data <= 1'b0;
          bus.tx_data     <= 1'b0;
          bus.busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rw_flow.sv
// Directed bench for rw_flow: one instance with a single-cycle access and one
// with a three-cycle access. Outputs are packed as
// {busy, tx_data, sample_data, rw_mem, access_mem} and checked 1 ns after each edge.
module tb_rw_flow;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rw_flow_if bus1 ();
  rw_flow_if bus3 ();

  rw_flow #(.ACCESS_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  rw_flow #(.ACCESS_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] O_IDLE = 5'b00000;
  localparam logic [4:0] O_RD   = 5'b10001;
  localparam logic [4:0] O_WR   = 5'b10011;
  localparam logic [4:0] O_SMP  = 5'b10100;
  localparam logic [4:0] O_TX   = 5'b11000;
  localparam logic [4:0] O_DONE = 5'b10000;

  function automatic logic [4:0] outs1();
    return {bus1.busy, bus1.tx_data, bus1.sample_data, bus1.rw_mem, bus1.access_mem};
  endfunction

  function automatic logic [4:0] outs3();
    return {bus3.busy, bus3.tx_data, bus3.sample_data, bus3.rw_mem, bus3.access_mem};
  endfunction

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    {bus1.active, bus1.mode, bus1.valid_cmd, bus1.rw, bus1.tx_done} = 5'b0;
    {bus3.active, bus3.mode, bus3.valid_cmd, bus3.rw, bus3.tx_done} = 5'b0;
    rst_n = 1'b0;

    // reset
    step();
    step();
    chk("in_reset", outs1(), O_IDLE);
    rst_n = 1'b1;
    step();
    chk("after_reset", outs1(), O_IDLE);
    chk("after_reset3", outs3(), O_IDLE);

    // read with a 16-cycle transmit
    bus1.active = 1'b1;
    bus1.mode   = 1'b1;
    bus1.rw     = 1'b0;
    bus1.valid_cmd = 1'b1;
    bus1.tx_done   = 1'b1;  // tx_done outside TX is ignored
    step();
    bus1.valid_cmd = 1'b0;
    chk("rd_access", outs1(), O_RD);
    step();
    bus1.tx_done = 1'b0;
    chk("rd_sample", outs1(), O_SMP);
    step();
    chk("rd_tx_first", outs1(), O_TX);
    for (int i = 1; i < 16; i++) begin
      step();
      chk("rd_tx_hold", outs1(), O_TX);
    end
    bus1.tx_done = 1'b1;
    step();
    bus1.tx_done = 1'b0;
    chk("rd_end", outs1(), O_IDLE);

    // write
    bus1.rw = 1'b1;
    bus1.valid_cmd = 1'b1;
    step();
    bus1.valid_cmd = 1'b0;
    chk("wr_access", outs1(), O_WR);
    step();
    chk("wr_done", outs1(), O_DONE);
    step();
    chk("wr_end", outs1(), O_IDLE);

    // commands blocked by mode=0, then by active=0
    bus1.mode = 1'b0;
    bus1.valid_cmd = 1'b1;
    step();
    chk("mode0_a", outs1(), O_IDLE);
    step();
    bus1.valid_cmd = 1'b0;
    chk("mode0_b", outs1(), O_IDLE);
    bus1.mode = 1'b1;
    bus1.active = 1'b0;
    bus1.valid_cmd = 1'b1;
    step();
    bus1.valid_cmd = 1'b0;
    chk("inactive_a", outs1(), O_IDLE);
    step();
    chk("inactive_b", outs1(), O_IDLE);
    bus1.active = 1'b1;

    // extra command during TX is ignored, then abort in TX
    bus1.rw = 1'b0;
    bus1.valid_cmd = 1'b1;
    step();
    bus1.valid_cmd = 1'b0;
    chk("rd2_access", outs1(), O_RD);
    step();
    step();
    chk("rd2_tx", outs1(), O_TX);
    bus1.rw = 1'b1;
    bus1.valid_cmd = 1'b1;
    step();
    bus1.valid_cmd = 1'b0;
    chk("rd2_tx_ignore", outs1(), O_TX);
    bus1.mode = 1'b0;  // mode drop mid-flow does not abort
    step();
    chk("rd2_mode0_hold", outs1(), O_TX);
    bus1.mode = 1'b1;
    bus1.active = 1'b0;
    step();
    chk("rd2_abort", outs1(), O_IDLE);
    bus1.active = 1'b1;
    step();
    chk("rd2_no_queue", outs1(), O_IDLE);

    // tx_done and valid_cmd on the same edge: command dropped
    bus1.rw = 1'b0;
    bus1.valid_cmd = 1'b1;
    step();
    bus1.valid_cmd = 1'b0;
    step();
    step();
    chk("rd3_tx", outs1(), O_TX);
    bus1.tx_done = 1'b1;
    bus1.rw = 1'b1;
    bus1.valid_cmd = 1'b1;
    step();
    bus1.tx_done = 1'b0;
    bus1.valid_cmd = 1'b0;
    chk("rd3_end_drop", outs1(), O_IDLE);
    step();
    chk("rd3_still_idle", outs1(), O_IDLE);

    // three-cycle access on the second instance, then reset mid-TX
    bus3.active = 1'b1;
    bus3.mode = 1'b1;
    bus3.rw = 1'b0;
    bus3.valid_cmd = 1'b1;
    step();
    bus3.valid_cmd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ac3_access", outs3(), O_RD);
      step();
    end
    chk("ac3_sample", outs3(), O_SMP);
    step();
    chk("ac3_tx", outs3(), O_TX);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset3", outs3(), O_IDLE);
    chk("async_reset1", outs1(), O_IDLE);
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset3", outs3(), O_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
